// File: rtl/pipelined_borrow_select_sub_pkg.sv
// Shared constants and stage-1 payload for the
// two-stage borrow-select subtractor.
package pipelined_borrow_select_sub_pkg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int LO_W   = 2 * SLICE;
  localparam int HI_N   = NSLICE - 2;

  // hi_diff/hi_bout indexed [upper slice][borrow-in]
  typedef struct packed {
    logic [LO_W-1:0]                  lo_diff;
    logic                             lo_bout;
    logic [HI_N-1:0][1:0][SLICE-1:0]  hi_diff;
    logic [HI_N-1:0][1:0]             hi_bout;
    logic                             a_msb;
    logic                             b_msb;
  } s1_t;

endpackage

// File: rtl/pipelined_borrow_select_sub_ripple_borrow_4bit.sv
// 4-bit ripple-borrow slice: diff = a - b - bin,
// bout set when the slice needs to borrow.
module ripple_borrow_4bit
  import pipelined_borrow_select_sub_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] diff,
  output logic             bout
);

  logic [SLICE:0] br;

  always_comb begin
    br    = '0;
    diff  = '0;
    br[0] = bin;
    for (int i = 0; i < SLICE; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) |
                 (~(a[i] ^ b[i]) & br[i]);
    end
    bout = br[SLICE];
  end

endmodule

// File: rtl/pipelined_borrow_select_sub.sv
// Two-stage 16-bit borrow-select subtractor with
// valid/ready on both sides and borrow/overflow/zero flags.
module pipelined_borrow_select_sub
  import pipelined_borrow_select_sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  logic s2_advance;
  logic accept;

  logic s1_valid_q, s1_valid_d;
  s1_t  s1_q, s1_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] lo0_diff, lo1_diff;
  logic             lo0_bout, lo1_bout;

  logic [HI_N-1:0][1:0][SLICE-1:0] hi_diff;
  logic [HI_N-1:0][1:0]            hi_bout;

  ripple_borrow_4bit u_lo0 (
    .a    (minuend[SLICE-1:0]),
    .b    (subtrahend[SLICE-1:0]),
    .bin  (1'b0),
    .diff (lo0_diff),
    .bout (lo0_bout)
  );

  ripple_borrow_4bit u_lo1 (
    .a    (minuend[LO_W-1:SLICE]),
    .b    (subtrahend[LO_W-1:SLICE]),
    .bin  (lo0_bout),
    .diff (lo1_diff),
    .bout (lo1_bout)
  );

  // Both borrow-in candidates for each upper slice
  for (genvar s = 0; s < HI_N; s++) begin : g_hi
    for (genvar c = 0; c < 2; c++) begin : g_cand
      ripple_borrow_4bit u_rb (
        .a    (minuend[LO_W+SLICE*s +: SLICE]),
        .b    (subtrahend[LO_W+SLICE*s +: SLICE]),
        .bin  (c == 1),
        .diff (hi_diff[s][c]),
        .bout (hi_bout[s][c])
      );
    end
  end

  assign s2_advance = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;
  assign accept     = in_valid && in_ready;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d      = 1'b1;
      s1_d.lo_diff    = {lo1_diff, lo0_diff};
      s1_d.lo_bout    = lo1_bout;
      s1_d.hi_diff    = hi_diff;
      s1_d.hi_bout    = hi_bout;
      s1_d.a_msb      = minuend[WIDTH-1];
      s1_d.b_msb      = subtrahend[WIDTH-1];
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  logic [WIDTH-1:0] sel_diff;
  logic             sel_bout;

  always_comb begin
    sel_diff = '0;
    sel_bout = s1_q.lo_bout;
    sel_diff[LO_W-1:0] = s1_q.lo_diff;
    for (int s = 0; s < HI_N; s++) begin
      sel_diff[LO_W+SLICE*s +: SLICE] =
        s1_q.hi_diff[s][sel_bout];
      sel_bout = s1_q.hi_bout[s][sel_bout];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = sel_diff;
        bout_d = sel_bout;
        ovf_d  = (s1_q.a_msb != s1_q.b_msb) &&
                 (sel_diff[WIDTH-1] != s1_q.a_msb);
        zero_d = (sel_diff == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign difference = diff_q;
  assign borrow_out = bout_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_pipelined_borrow_select_sub.sv
// Bench for pipelined_borrow_select_sub: directed and
// random operations checked against an arithmetic model.
module tb_pipelined_borrow_select_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] minuend = '0;
  logic [15:0] subtrahend = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] difference;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  pipelined_borrow_select_sub dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int released = 0;
  logic [18:0] q[$];

  // {difference, borrow, overflow, zero}
  function automatic logic [18:0] model(
    input logic [15:0] a, input logic [15:0] b);
    int sd;
    logic [15:0] d;
    logic o;
    sd = int'($signed(a)) - int'($signed(b));
    o  = (sd > 32767) || (sd < -32768);
    d  = a - b;
    return {d, a < b, o, d == 16'd0};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic tick(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      released++;
      chk("result_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        chk("result",
            {13'd0, difference, borrow_out, overflow, zero},
            {13'd0, q[0]});
        void'(q.pop_front());
      end
    end
    if (acc) q.push_back(model(minuend, subtrahend));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a,
                      input logic [15:0] b);
    bit acc;
    minuend    = a;
    subtrahend = b;
    in_valid   = 1'b1;
    acc        = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      if (acc) break;
    end
    chk("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick(acc);
    end
    chk("drain_empty", q.size(), 0);
  endtask

  logic [15:0] va[4] = '{16'h0003, 16'h1234, 16'h8000, 16'h00FF};
  logic [15:0] vb[4] = '{16'h0005, 16'h1234, 16'h0001, 16'h0100};

  initial begin
    bit acc;
    int base;
    int idx;
    logic [15:0] hold;
    logic [15:0] sa[3];
    logic [15:0] sb[3];

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_difference", difference, 0);
    chk("rst_flags", {borrow_out, overflow, zero}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Latency: accept at edge k, visible after k+1
    send(16'h0005, 16'h0003);
    tick(acc);
    chk("lat_valid", out_valid, 1);
    chk("lat_diff", difference, 16'h0002);
    chk("lat_flags", {borrow_out, overflow, zero}, 0);
    drain();

    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i]);
      drain();
    end

    // Back-to-back with out_ready held high
    base = released;
    for (int i = 0; i < 8; i++) begin
      minuend    = 16'($urandom);
      subtrahend = 16'($urandom);
      in_valid   = 1'b1;
      chk("b2b_in_ready", in_ready, 1);
      if (i >= 2) chk("b2b_out_valid", out_valid, 1);
      tick(acc);
      chk("b2b_accept", acc, 1);
    end
    drain();
    chk("b2b_count", released - base, 8);

    // Output stall with three pending operations
    for (int i = 0; i < 3; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    base = released;
    out_ready = 1'b0;
    idx  = 0;
    hold = '0;
    for (int c = 0; c < 5; c++) begin
      minuend    = sa[idx < 3 ? idx : 2];
      subtrahend = sb[idx < 3 ? idx : 2];
      in_valid   = (idx < 3);
      tick(acc);
      if (acc) idx++;
      if (c == 1) hold = difference;
      if (c >= 2) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", difference, hold);
      end
    end
    chk("stall_accepted", idx, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_no_release", released - base, 0);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    while (idx < 3) begin
      send(sa[idx], sb[idx]);
      idx++;
    end
    drain();
    chk("stall_count", released - base, 3);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    send(16'h4321, 16'h1111);
    send(16'h0001, 16'h0002);
    #2;
    rst_n = 1'b0;
    #2;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_difference", difference, 0);
    chk("arst_flags", {borrow_out, overflow, zero}, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    base = released;
    send(16'h7FFF, 16'hFFFF);
    drain();
    for (int i = 0; i < 3; i++) tick(acc);
    chk("post_rst_count", released - base, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
